// File: rtl/data_memory_ctrl_pkg.sv
// Shared types and helpers for the data memory controller.
// Write logging is enabled by defining DM_WRITE_LOG_EN.
package data_memory_ctrl_pkg;

    localparam int DM_ADDR_WIDTH = 10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } dm_state_e;

    // Replace only the byte lanes selected by be.
    function automatic logic [31:0] dm_merge(
        input logic [31:0] old_w,
        input logic [31:0] wd,
        input logic [3:0]  be
    );
        logic [31:0] w_res;
        w_res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) w_res[8*i +: 8] = wd[8*i +: 8];
        end
        return w_res;
    endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Memory-stage bus between the pipeline and the data memory.
// Write logging is enabled by defining DM_WRITE_LOG_EN.
interface data_memory_ctrl_if;
    logic [31:0] A;
    logic        WE;
    logic [3:0]  BE;
    logic [31:0] WD;
    logic [31:0] PC;
    logic [31:0] RD;
    logic        busy;
    logic        err;

    modport master (
        output A, WE, BE, WD, PC,
        input  RD, busy, err
    );

    modport slave (
        input  A, WE, BE, WD, PC,
        output RD, busy, err
    );
endinterface

// File: rtl/data_memory_ctrl_dm_byte_merge.sv
// Combinational byte-lane merge of store data into the old word.
// Write logging is enabled by defining DM_WRITE_LOG_EN.
module dm_byte_merge
    import data_memory_ctrl_pkg::*;
(
    input  logic [31:0] i_old,
    input  logic [31:0] i_wd,
    input  logic [3:0]  i_be,
    output logic [31:0] o_new
);
    assign o_new = dm_merge(i_old, i_wd, i_be);
endmodule

// File: rtl/data_memory_ctrl.sv
// Word-addressed data memory with post-reset clear sweep.
// Define DM_WRITE_LOG_EN to print every committed store.
module data_memory_ctrl
    import data_memory_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DM_ADDR_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    data_memory_ctrl_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           r_mem [DEPTH];
    dm_state_e             r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_err;

    logic                  w_in_range;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_busy;
    logic [31:0]           w_old;
    logic [31:0]           w_merged;
    logic                  w_wr_req;
    logic                  w_commit;
    logic                  w_oob;

    assign w_in_range = (bus.A[31:ADDR_WIDTH+2] == '0);
    assign w_idx      = bus.A[ADDR_WIDTH+1:2];
    assign w_busy     = (r_state == ST_CLEAR);
    assign w_old      = r_mem[w_idx];
    // Stores during reset or the sweep are dropped.
    assign w_wr_req   = bus.WE && (|bus.BE) && !w_busy && !reset;
    assign w_commit   = w_wr_req && w_in_range;
    assign w_oob      = w_wr_req && !w_in_range;

    assign bus.RD   = (w_in_range && !w_busy) ? w_old : 32'h0;
    assign bus.busy = w_busy;
    assign bus.err  = r_err;

    dm_byte_merge u_merge (
        .i_old (w_old),
        .i_wd  (bus.WD),
        .i_be  (bus.BE),
        .o_new (w_merged)
    );

    // Clear FSM: sweep every word once after reset, then stay idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_ptr <= r_ptr + 1'b1;
            if (r_ptr == '1) r_state <= ST_IDLE;
        end
    end

    // One-cycle error pulse for an out-of-range store.
    always_ff @(posedge clk) begin
        if (reset) r_err <= 1'b0;
        else       r_err <= w_oob;
    end

    // Storage: sweep zeroing or a merged store; untouched in reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_busy) begin
                r_mem[r_ptr] <= 32'h0;
            end else if (w_commit) begin
                r_mem[w_idx] <= w_merged;
`ifdef DM_WRITE_LOG_EN
                $display("%d@%h: *%h <= %h", $time, bus.PC,
                         {bus.A[31:2], 2'b00}, w_merged);
`else
`endif
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomized bench for data_memory_ctrl against an array model.
// Write logging is enabled by defining DM_WRITE_LOG_EN.
module tb_data_memory_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_memory_ctrl_if bus ();

    data_memory_ctrl #(.ADDR_WIDTH(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] mref [1024];
    logic        exp_err;
    int          cnt;
    logic [31:0] got;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >> 12) == 0;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (!in_rng(a)) return 32'h0;
        return mref[(a % 4096) / 4];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) mref[i] = 32'h0;
        exp_err = 1'b0;
    endtask

    // One idle-state cycle: drive at negedge, check, then update model.
    task automatic cyc(input logic [31:0] a, input logic we,
                       input logic [3:0] be, input logic [31:0] wd,
                       output logic [31:0] rd);
        logic [31:0] w;
        @(negedge clk);
        bus.A = a; bus.WE = we; bus.BE = be; bus.WD = wd;
        bus.PC = $urandom;
        #1;
        rd = bus.RD;
        check("rd", bus.RD, model_rd(a));
        check("err", {31'h0, bus.err}, {31'h0, exp_err});
        check("idle", {31'h0, bus.busy}, 32'h0);
        exp_err = 1'b0;
        if (we && be != 4'h0) begin
            if (in_rng(a)) begin
                w = mref[(a % 4096) / 4];
                for (int i = 0; i < 4; i++)
                    if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
                mref[(a % 4096) / 4] = w;
            end else begin
                exp_err = 1'b1;
            end
        end
    endtask

    // Count busy cycles while hammering the bus with stores to drop.
    task automatic sweep(input int abort_at, output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 2000) begin
            if (n == abort_at) return;
            n++;
            bus.A  = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            bus.WE = 1'b1; bus.BE = 4'hF; bus.WD = $urandom;
            #1;
            check("busy_rd", bus.RD, 32'h0);
            check("busy_err", {31'h0, bus.err}, 32'h0);
            @(negedge clk); #1;
        end
        bus.WE = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        reset = 1'b1;
        bus.A = 0; bus.WE = 0; bus.BE = 0; bus.WD = 0; bus.PC = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'h0, bus.busy}, 32'h1);
        check("rst_err", {31'h0, bus.err}, 32'h0);
        reset = 1'b0;
        #1;
        sweep(-1, cnt);
        check("sweep_len", cnt, 1024);
        model_clear();

        cyc(32'h0, 0, 0, 0, got);
        check("clr0", got, 32'h0);
        cyc(32'hFFC, 0, 0, 0, got);
        check("clrFFC", got, 32'h0);
        cyc(32'h800, 0, 0, 0, got);
        check("clr800", got, 32'h0);

        cyc(32'h10, 1, 4'hF, 32'h12345678, got);
        cyc(32'h11, 1, 4'b0010, 32'h0000AB00, got);
        check("same_cyc", got, 32'h12345678);
        cyc(32'h10, 0, 0, 0, got);
        check("lane1", got, 32'h1234AB78);
        cyc(32'h1000, 1, 4'hF, 32'hCAFEF00D, got);
        check("oob_rd", got, 32'h0);
        cyc(32'h0, 0, 0, 0, got);
        check("oob_err", {31'h0, bus.err}, 32'h1);
        check("oob_mem0", got, 32'h0);
        cyc(32'h10, 1, 4'h0, 32'hFFFFFFFF, got);
        check("err_pulse", {31'h0, bus.err}, 32'h0);
        cyc(32'h10, 0, 0, 0, got);
        check("be0_nop", got, 32'h1234AB78);

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) < 8) begin
                a = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom)};
                if ($urandom_range(0, 1) == 1) a[11:6] = 6'h0;
            end else begin
                a = $urandom;
                if (a[31:12] == 0) a[12] = 1'b1;
            end
            cyc(a, 1'($urandom), 4'($urandom), $urandom, got);
        end
        cyc(32'h10, 0, 0, 0, got);

        // Reset mid-sweep with a store presented in the reset cycle.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        sweep(500, cnt);
        check("abort_at", cnt, 500);
        reset = 1'b1;
        bus.A = 32'h20; bus.WE = 1; bus.BE = 4'hF; bus.WD = 32'hDEADBEEF;
        @(negedge clk);
        reset = 1'b0;
        bus.WE = 1'b0;
        #1;
        sweep(-1, cnt);
        check("resweep_len", cnt, 1024);
        model_clear();
        cyc(32'h20, 0, 0, 0, got);
        check("rst_wr_drop", got, 32'h0);

        for (int k = 0; k < 200; k++) begin
            a = {20'h0, 10'($urandom_range(0, 31)), 2'b00};
            cyc(a, 1'($urandom), 4'($urandom), $urandom, got);
        end
        cyc(32'h0, 0, 0, 0, got);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set the word-index width; depth = 2**ADDR_WIDTH 32-bit words (4 KiB at default).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 A  input  32  SHALL carry the byte address from the memory stage (ALU result).
REQ-005 WE  input  1  SHALL be the store strobe.
REQ-006 BE  input  4  SHALL be the byte enables; bit i covers WD[8i+7:8i].
REQ-007 WD  input  32  SHALL be the store data, already lane-aligned by the requester.
REQ-008 PC  input  32  SHALL be the PC of the instruction performing the access, used only for logging.
REQ-009 RD  output  32  SHALL be the read data for word A.
REQ-010 busy  output  1  SHALL be high while the post-reset clear sweep runs, so the pipeline can stall.
REQ-011 err  output  1  SHALL be a registered one-cycle pulse that flags an out-of-range access.

Function
REQ-012 Word index SHALL be A[ADDR_WIDTH+1:2]; A[1:0] SHALL be ignored.
REQ-013 An access SHALL be in range iff A[31:ADDR_WIDTH+2] == 0.
REQ-014 RD SHALL be combinational: mem[index] when in range and busy=0, otherwise 32'h0.
REQ-015 A write SHALL commit at posedge clk when WE=1, busy=0 and the address is in range.
REQ-016 A committed write SHALL update only the lanes with BE[i]=1.
REQ-017 WE=1 with BE=4'b0000 SHALL be a no-op: no memory change, no log line, no err.
REQ-018 Same-cycle read and write to the same word: RD SHALL show the pre-write contents; the new value SHALL be visible from the next cycle.
REQ-019 Out-of-range WE=1 SHALL leave memory unchanged and set err=1 in the following cycle for exactly one cycle.
REQ-020 Accesses while busy=1 SHALL be dropped silently (no write, RD=0, no err).
REQ-021 The clear FSM SHALL have two states, CLEAR and IDLE, with a word pointer ptr of ADDR_WIDTH bits.
REQ-022 In CLEAR, the block SHALL write mem[ptr]<=0 and increment ptr each cycle.
REQ-023 CLEAR SHALL transition to IDLE in the cycle after ptr == depth-1 is written; busy SHALL be high in CLEAR and low in IDLE.
REQ-024 IDLE SHALL be terminal until the next reset.

Reset
REQ-025 While reset=1 at posedge clk: state<=CLEAR, ptr<=0, err<=0; memory contents are not touched in that cycle.
REQ-026 On the first posedge after reset deasserts, the sweep SHALL start at word 0; busy SHALL be 1 from the reset cycle onward.
REQ-027 Reset asserted mid-sweep SHALL restart the sweep at ptr=0.
REQ-028 Reset asserted during IDLE SHALL re-enter CLEAR; a write presented in the same cycle as reset SHALL be dropped.

Configuration
REQ-029 With DM_WRITE_LOG_EN defined, each committed write SHALL $display "%d@%h: *%h <= %h" with $time, PC, word-aligned address {A[31:2],2'b00}, and the merged 32-bit word.
REQ-030 With DM_WRITE_LOG_EN undefined, no display SHALL be compiled and PC SHALL be unused but still present as a port.
REQ-031 Clear-sweep writes SHALL never be logged.

Structure
REQ-032 A shared package SHALL hold the state encoding (CLEAR=1'b1, IDLE=1'b0), the default ADDR_WIDTH, and the byte-merge function.
REQ-033 One sub-module, dm_byte_merge, SHALL be used: a combinational merge of old word, WD and BE into the new word.
REQ-034 The storage array, FSM, err register and logging SHALL stay in data_memory_ctrl.

Verification
REQ-035 Reset held 2 cycles, then released -> busy=1 for exactly 1024 cycles, then 0; reads of 0x0, 0xFFC and 0x800 -> 0.
REQ-036 After clear: WE=1, BE=4'hF, A=0x10, WD=0x12345678, PC=0x3000 -> next cycle RD@0x10=0x12345678; log "@00003000: *00000010 <= 12345678" when DM_WRITE_LOG_EN is defined.
REQ-037 Then WE=1, BE=4'b0010, A=0x11, WD=0x0000AB00 -> RD@0x10=0x1234AB78; the same-cycle RD shows 0x12345678.
REQ-038 WE=1, BE=4'hF, A=0x1000 -> err=1 for one cycle; RD@0x1000=0; RD@0x0 unchanged.
REQ-039 Reset pulsed at sweep cycle 500, then a write of 0xDEADBEEF to 0x20 in the reset cycle -> the sweep restarts (busy for 1024 more cycles); RD@0x20=0 afterwards.
REQ-040 WE=1, BE=0, A=0x10 -> memory unchanged, err=0, no log line.
